alu_operand_driver: RTL and testbench
=====================================

# alu_operand_driver

Initiator-side driver for the 32-bit adder ALU datapath. It accepts operand pairs over a valid/ready request port and drives them onto the ALU's `ArgA`/`ArgB` inputs. It waits a fixed, parameterised settling latency, then samples the ALU `Result`, compares it against a locally computed `ArgA+ArgB`, and returns the result with carry, signed-overflow and mismatch flags over a valid/ready response port. It sits between the operand source (sequencer or bus bridge) and the ALU, and doubles as an in-system self-check of the ALU.

## Interface
- `WIDTH`, 32: operand and result width.
- `LATENCY`, 2: number of `Clk` edges from operands being driven to `Result` being sampled; legal range 1..15.
- `Clk`  in  1  clock, all state updates on rising edge.
- `Rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `ReqValid`  in  1  operand pair valid.
- `ReqReady`  out  1  driver can accept a request.
- `ReqA`  in  WIDTH  operand A.
- `ReqB`  in  WIDTH  operand B.
- `ArgA`  out  WIDTH  operand A to ALU (registered).
- `ArgB`  out  WIDTH  operand B to ALU (registered).
- `Result`  in  WIDTH  ALU result.
- `RspValid`  out  1  response valid.
- `RspReady`  in  1  response consumer ready.
- `RspData`  out  WIDTH  sampled ALU `Result`.
- `RspCarry`  out  1  bit WIDTH of the expected unsigned sum.
- `RspOvf`  out  1  signed overflow of A+B.
- `RspMismatch`  out  1  sampled `Result` differs from expected sum.
- `ErrCount`  out  8  saturating mismatch count.

## Operation
- FSM states:
  - IDLE: `ReqReady`=1. On `ReqValid`&&`ReqReady`: register ReqA/ReqB into `ArgA`/`ArgB` and compute expected sum into a WIDTH+1-bit register. Compute overflow as (A[msb]==B[msb]) && (sum[msb]!=A[msb]). Load the wait counter with LATENCY-1 and go to WAIT.
  - WAIT: on each edge, if the counter is 0, capture `Result` into `RspData`, set `RspMismatch`=(Result != sum[WIDTH-1:0]), set `RspCarry`/`RspOvf` from the expected sum, and go to RESP. Otherwise decrement the counter.
  - RESP: `RspValid`=1. On `RspValid`&&`RspReady`, go to IDLE.
- `ReqReady` = (state==IDLE) && `Rst_n`. It is combinational from state; requests are never accepted outside IDLE.
- `ArgA`/`ArgB` hold their last accepted values until the next accept; they are never cleared except by reset.
- Response fields (`RspData`, flags) are stable from the capture edge through the RESP handshake edge. They keep their values in IDLE.
- `ErrCount`:
  - increments by 1 on a capture edge with mismatch;
  - saturates at 255;
  - is cleared only by reset.
- Arithmetic is unsigned modulo 2^WIDTH for `RspData`/compare; carry and overflow are reported independently.

## Timing
- Reset: while `Rst_n`=0 at an edge, state goes to IDLE and counter=0. The following outputs clear to 0: `ArgA`, `ArgB`, `RspData`, `RspCarry`, `RspOvf`, `RspMismatch`, `ErrCount`. `RspValid`=0 and `ReqReady`=0 while `Rst_n`=0.
- Reset mid-WAIT or mid-RESP aborts the transaction; no response is emitted and `ErrCount` is not updated.
- Request accepted at edge t:
  - `ArgA`/`ArgB` update at edge t;
  - `Result` is sampled at edge t+LATENCY;
  - `RspValid` is high from edge t+LATENCY.
- Response accepted at edge r: `ReqReady` high after r; next accept no earlier than edge r+1.
- Maximum throughput is one transaction per LATENCY+2 cycles with `ReqValid` and `RspReady` held high.
- `RspReady` held low: `RspValid` and all Rsp fields hold indefinitely; `ReqReady` stays 0.
- `ReqValid` deasserting while `ReqReady`=0 has no effect; no request is buffered.

## Test plan
- Behavioural ALU model (Result = ArgA+ArgB, valid LATENCY cycles after change), LATENCY=2, requests issued in sequence:
  - 0x01234567+0x89abcdef -> RspData 0x8acf1356, carry 0, ovf 0, mismatch 0.
  - 0x80000000+0x80000000 -> 0x00000000, carry 1, ovf 1.
  - 0x80000000+0x7fffffff -> 0xffffffff, carry 0, ovf 0.
  - 0x7fffffff+0x7fffffff -> 0xfffffffe, carry 0, ovf 1.
  - `ErrCount` remains 0 throughout.
- Backpressure: `RspReady` low for 5 cycles after `RspValid` -> `RspValid`/`RspData` held constant, `ReqReady`=0 throughout. Handshake on cycle 6 -> `ReqReady`=1 the next cycle.
- Fault injection: model returns Result^0x1 -> `RspMismatch`=1 and `ErrCount` increments by 1. 300 consecutive faulty transactions -> `ErrCount`=255, no wrap.
- Reset: `Rst_n` low for one edge while in WAIT -> no `RspValid`, all outputs 0. A new request is accepted one cycle after `Rst_n` returns high.
- LATENCY=1 build with `ReqValid`/`RspReady` tied high -> `RspValid` one cycle after accept; accepts spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/alu_operand_driver.sv
// alu_operand_driver
// Drives operand pairs onto a 32-bit adder ALU and waits a fixed settling
// latency. It then samples the ALU result, checks it against a locally
// computed sum, and returns the result with carry, signed-overflow and
// mismatch flags. A saturating counter records how many results were wrong.
module alu_operand_driver #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [WIDTH-1:0] ReqA,
    input  logic [WIDTH-1:0] ReqB,
    output logic [WIDTH-1:0] ArgA,
    output logic [WIDTH-1:0] ArgB,
    input  logic [WIDTH-1:0] Result,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspData,
    output logic             RspCarry,
    output logic             RspOvf,
    output logic             RspMismatch,
    output logic [7:0]       ErrCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter starts at LATENCY-1 so that Result is sampled exactly
    // LATENCY edges after the operands were driven.
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       wait_cnt;
    logic [WIDTH:0]   exp_sum;
    logic             exp_ovf;
    logic             accept;
    logic             capture;
    logic             mismatch;

    // Two's-complement overflow: both operands share a sign and the
    // truncated sum has the other sign.
    function automatic logic add_overflow(input logic signed [WIDTH-1:0] a,
                                          input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] s;
        s = a + b;
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Handshake outputs are forced low while reset is asserted.
    assign ReqReady = (state == IDLE) && Rst_n;
    assign RspValid = (state == RESP) && Rst_n;
    assign mismatch = (Result != exp_sum[WIDTH-1:0]);

    // Next-state logic; also produces the accept and capture strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (ReqValid && ReqReady) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (RspReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Settling counter, loaded on accept and counted down while waiting.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_INIT;
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Operand registers and the expected sum/overflow computed at accept.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ArgA    <= '0;
            ArgB    <= '0;
            exp_sum <= '0;
            exp_ovf <= 1'b0;
        end else if (accept) begin
            ArgA    <= ReqA;
            ArgB    <= ReqB;
            exp_sum <= {1'b0, ReqA} + {1'b0, ReqB};
            exp_ovf <= add_overflow($signed(ReqA), $signed(ReqB));
        end
    end

    // Response fields: loaded once at capture and held until the next capture.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            RspData     <= '0;
            RspCarry    <= 1'b0;
            RspOvf      <= 1'b0;
            RspMismatch <= 1'b0;
        end else if (capture) begin
            RspData     <= Result;
            RspCarry    <= exp_sum[WIDTH];
            RspOvf      <= exp_ovf;
            RspMismatch <= mismatch;
        end
    end

    // Saturating count of ALU results that disagreed with the expected sum.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ErrCount <= 8'd0;
        end else if (capture && mismatch) begin
            ErrCount <= sat_inc8(ErrCount);
        end
    end

endmodule

// File: tb/tb_alu_operand_driver.sv
// Testbench for alu_operand_driver: a LATENCY=2 instance against a
// registered ALU model with fault injection, and a LATENCY=1 instance with
// request/response handshakes tied high.
module tb_alu_operand_driver;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         req_valid;
    logic         rsp_ready;
    logic         fault;
    logic [W-1:0] req_a, req_b, result, arg_a, arg_b, rsp_data;
    logic         req_ready, rsp_valid, rsp_carry, rsp_ovf, rsp_mism;
    logic [7:0]   err_count;
    logic [W-1:0] alu_r;

    logic [W-1:0] req_a_1, req_b_1, result_1, arg_a_1, arg_b_1, rsp_data_1;
    logic         req_ready_1, rsp_valid_1, rsp_carry_1, rsp_ovf_1, rsp_mism_1;
    logic [7:0]   err_count_1;

    int checks = 0;
    int errors = 0;
    int err_model = 0;

    alu_operand_driver #(.WIDTH(W), .LATENCY(2)) dut (
        .Clk(clk), .Rst_n(rst_n), .ReqValid(req_valid), .ReqReady(req_ready),
        .ReqA(req_a), .ReqB(req_b), .ArgA(arg_a), .ArgB(arg_b), .Result(result),
        .RspValid(rsp_valid), .RspReady(rsp_ready), .RspData(rsp_data),
        .RspCarry(rsp_carry), .RspOvf(rsp_ovf), .RspMismatch(rsp_mism),
        .ErrCount(err_count)
    );

    alu_operand_driver #(.WIDTH(W), .LATENCY(1)) u_lat1 (
        .Clk(clk), .Rst_n(rst_n), .ReqValid(1'b1), .ReqReady(req_ready_1),
        .ReqA(req_a_1), .ReqB(req_b_1), .ArgA(arg_a_1), .ArgB(arg_b_1),
        .Result(result_1), .RspValid(rsp_valid_1), .RspReady(1'b1),
        .RspData(rsp_data_1), .RspCarry(rsp_carry_1), .RspOvf(rsp_ovf_1),
        .RspMismatch(rsp_mism_1), .ErrCount(err_count_1)
    );

    // ALU model for the LATENCY=2 instance: one register stage, optional bit-0 fault.
    always @(posedge clk) alu_r <= (arg_a + arg_b) ^ {{(W-1){1'b0}}, fault};
    assign result   = alu_r;
    // ALU model for the LATENCY=1 instance: combinational adder.
    assign result_1 = arg_a_1 + arg_b_1;

    // Reference: full-precision unsigned sum (bit W is carry).
    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] u;
        u = 64'(a) + 64'(b);
        return u[W:0];
    endfunction

    // Reference: signed sum out of the 32-bit two's-complement range.
    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        return (s > 64'sd2147483647) || (s < -(64'sd2147483648));
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic complete_rsp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; fault = 1'b0;
        req_a = '0; req_b = '0; req_a_1 = '0; req_b_1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({arg_a, arg_b, rsp_data, rsp_carry, rsp_ovf, rsp_mism, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got arg_a=%h arg_b=%h data=%h c=%b o=%b m=%b err=%0d want all zero",
                     arg_a, arg_b, rsp_data, rsp_carry, rsp_ovf, rsp_mism, err_count);
        end
        checks++;
        if ({req_ready, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_handshake got ready=%b valid=%b want 0 0", req_ready, rsp_valid);
        end
        checks++;
        if (req_ready_1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_lat1 got %b want 0", req_ready_1);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [4] = '{32'h01234567, 32'h80000000, 32'h80000000, 32'h7fffffff};
        logic [W-1:0] tb [4] = '{32'h89abcdef, 32'h80000000, 32'h7fffffff, 32'h7fffffff};
        logic [W-1:0] td [4] = '{32'h8acf1356, 32'h00000000, 32'hffffffff, 32'hfffffffe};
        logic [2:0]   tf [4] = '{3'b000, 3'b110, 3'b000, 3'b010};
        int n;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i]);
            checks++;
            if ({arg_a, arg_b} !== {ta[i], tb[i]}) begin
                errors++;
                $display("FAIL dir%0d_args got %h %h want %h %h", i, arg_a, arg_b, ta[i], tb[i]);
            end
            wait_rsp(n);
            checks++;
            if (n != 2) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d want 2", i, n);
            end
            checks++;
            if (rsp_data !== td[i]) begin
                errors++;
                $display("FAIL dir%0d_data got %h want %h", i, rsp_data, td[i]);
            end
            checks++;
            if ({rsp_carry, rsp_ovf, rsp_mism} !== tf[i]) begin
                errors++;
                $display("FAIL dir%0d_flags got c/o/m=%b want %b", i, {rsp_carry, rsp_ovf, rsp_mism}, tf[i]);
            end
            checks++;
            if (err_count !== 8'd0) begin
                errors++;
                $display("FAIL dir%0d_errcount got %0d want 0", i, err_count);
            end
            complete_rsp();
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] a = 32'h1234_0001;
        logic [W-1:0] b = 32'h0000_fffe;
        logic [W:0]   s;
        int n;
        s = model_sum(a, b);
        issue(a, b);
        wait_rsp(n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL bp_latency got %0d want 2", n);
        end
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_a = 32'hdead_beef;
            req_b = 32'h0bad_f00d;
            @(negedge clk);
            checks++;
            if ({rsp_valid, req_ready, rsp_data} !== {1'b1, 1'b0, s[W-1:0]}) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%b ready=%b data=%h want 1 0 %h",
                         i, rsp_valid, req_ready, rsp_data, s[W-1:0]);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        checks++;
        if ({arg_a, rsp_data} !== {a, s[W-1:0]}) begin
            errors++;
            $display("FAIL bp_idle_hold got arg_a=%h data=%h want %h %h", arg_a, rsp_data, a, s[W-1:0]);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] corners [6] = '{32'h0, 32'hffffffff, 32'h80000000, 32'h7fffffff, 32'h1, 32'h80000001};
        logic [W-1:0] a, b;
        logic [W:0]   s;
        logic         o;
        int n;
        for (int i = 0; i < 24; i++) begin
            a = (i % 3 == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            b = (i % 4 == 1) ? corners[$urandom_range(0, 5)] : W'($urandom);
            s = model_sum(a, b);
            o = model_ovf(a, b);
            issue(a, b);
            wait_rsp(n);
            checks++;
            if (n != 2 || rsp_data !== s[W-1:0]) begin
                errors++;
                $display("FAIL rnd%0d_data got %h after %0d want %h after 2", i, rsp_data, n, s[W-1:0]);
            end
            checks++;
            if ({rsp_carry, rsp_ovf, rsp_mism} !== {s[W], o, 1'b0}) begin
                errors++;
                $display("FAIL rnd%0d_flags a=%h b=%h got c/o/m=%b want %b",
                         i, a, b, {rsp_carry, rsp_ovf, rsp_mism}, {s[W], o, 1'b0});
            end
            complete_rsp();
        end
    endtask

    task automatic test_fault;
        logic [W-1:0] a, b;
        logic [W:0]   s;
        int n;
        fault = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = model_sum(a, b);
            issue(a, b);
            wait_rsp(n);
            err_model = (err_model < 255) ? err_model + 1 : 255;
            checks++;
            if (n != 2 || rsp_mism !== 1'b1 || rsp_data !== (s[W-1:0] ^ 32'h1)) begin
                errors++;
                $display("FAIL fault%0d got mism=%b data=%h after %0d want 1 %h after 2",
                         i, rsp_mism, rsp_data, n, s[W-1:0] ^ 32'h1);
            end
            checks++;
            if (err_count !== 8'(err_model)) begin
                errors++;
                $display("FAIL fault%0d_errcount got %0d want %0d", i, err_count, err_model);
            end
            complete_rsp();
        end
        fault = 1'b0;
        issue(32'h5, 32'h7);
        wait_rsp(n);
        checks++;
        if ({rsp_mism, rsp_data, err_count} !== {1'b0, 32'hc, 8'd255}) begin
            errors++;
            $display("FAIL fault_clean got mism=%b data=%h err=%0d want 0 0000000c 255",
                     rsp_mism, rsp_data, err_count);
        end
        complete_rsp();
    endtask

    task automatic test_reset_mid_wait;
        logic [W:0] s;
        int n;
        issue(32'h1111_1111, 32'h2222_2222);
        rst_n = 1'b0;
        @(negedge clk);
        err_model = 0;
        checks++;
        if ({arg_a, arg_b, rsp_data, rsp_carry, rsp_ovf, rsp_mism, err_count, rsp_valid, req_ready} !== '0) begin
            errors++;
            $display("FAIL midwait_reset got arg_a=%h data=%h err=%0d valid=%b ready=%b want all zero",
                     arg_a, rsp_data, err_count, rsp_valid, req_ready);
        end
        s = model_sum(32'h0f0f_0f0f, 32'h0101_0101);
        rst_n = 1'b1;
        req_a = 32'h0f0f_0f0f;
        req_b = 32'h0101_0101;
        req_valid = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL midwait_ready got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (arg_a !== 32'h0f0f_0f0f) begin
            errors++;
            $display("FAIL midwait_accept got %h want 0f0f0f0f", arg_a);
        end
        wait_rsp(n);
        checks++;
        if (n != 2 || rsp_data !== s[W-1:0] || err_count !== 8'(err_model)) begin
            errors++;
            $display("FAIL midwait_rsp got data=%h after %0d err=%0d want %h after 2 err 0",
                     rsp_data, n, err_count, s[W-1:0]);
        end
        complete_rsp();
    endtask

    task automatic test_latency1_throughput;
        int           acc_idx [$];
        logic [W:0]   exp_q [$];
        logic         ovf_q [$];
        int           last_acc = -1;
        int           accepts = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid_1 && acc_idx.size() > 0) begin
                checks++;
                if (acc_idx[0] + 2 != i) begin
                    errors++;
                    $display("FAIL lat1_rsp_timing got negedge %0d want %0d", i, acc_idx[0] + 2);
                end
                checks++;
                if ({rsp_data_1, rsp_carry_1, rsp_ovf_1, rsp_mism_1} !==
                    {exp_q[0][W-1:0], exp_q[0][W], ovf_q[0], 1'b0}) begin
                    errors++;
                    $display("FAIL lat1_data got %h c=%b o=%b m=%b want %h c=%b o=%b m=0",
                             rsp_data_1, rsp_carry_1, rsp_ovf_1, rsp_mism_1,
                             exp_q[0][W-1:0], exp_q[0][W], ovf_q[0]);
                end
                void'(acc_idx.pop_front());
                void'(exp_q.pop_front());
                void'(ovf_q.pop_front());
            end
            req_a_1 = W'($urandom);
            req_b_1 = W'($urandom);
            if (req_ready_1) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (i - last_acc != 3) begin
                        errors++;
                        $display("FAIL lat1_spacing got %0d want 3", i - last_acc);
                    end
                end
                last_acc = i;
                accepts++;
                acc_idx.push_back(i);
                exp_q.push_back(model_sum(req_a_1, req_b_1));
                ovf_q.push_back(model_ovf(req_a_1, req_b_1));
            end
        end
        checks++;
        if (accepts < 12 || err_count_1 !== 8'd0) begin
            errors++;
            $display("FAIL lat1_progress got accepts=%0d err=%0d want >=12 and 0", accepts, err_count_1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_fault();
        test_reset_mid_wait();
        test_latency1_throughput();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
